// File: rtl/mux_l1_tx_if.sv
// Lane bundle for the level-1 TX combiner: four input lanes with valids,
// per-channel ready, and two serialised output lanes with valid/overflow.
interface mux_l1_tx_if #(
    parameter int BUS_WIDTH = 8
);
    logic [BUS_WIDTH-1:0] Entrada0;
    logic [BUS_WIDTH-1:0] Entrada1;
    logic [BUS_WIDTH-1:0] Entrada2;
    logic [BUS_WIDTH-1:0] Entrada3;
    logic                 validEntrada0;
    logic                 validEntrada1;
    logic                 validEntrada2;
    logic                 validEntrada3;
    logic                 ready0;
    logic                 ready1;
    logic [BUS_WIDTH-1:0] Salida0;
    logic [BUS_WIDTH-1:0] Salida1;
    logic                 validsalida0;
    logic                 validsalida1;
    logic                 overflow0;
    logic                 overflow1;

    modport master (
        output Entrada0, Entrada1, Entrada2, Entrada3,
        output validEntrada0, validEntrada1, validEntrada2, validEntrada3,
        input  ready0, ready1,
        input  Salida0, Salida1, validsalida0, validsalida1,
        input  overflow0, overflow1
    );

    modport slave (
        input  Entrada0, Entrada1, Entrada2, Entrada3,
        input  validEntrada0, validEntrada1, validEntrada2, validEntrada3,
        output ready0, ready1,
        output Salida0, Salida1, validsalida0, validsalida1,
        output overflow0, overflow1
    );
endinterface

// File: rtl/mux_l1_tx.sv
// Level-1 TX lane combiner: two independent channels, each serialising a
// lo/hi lane pair onto one output lane over two consecutive cycles.
module mux_l1_tx #(
    parameter int                   BUS_WIDTH = 8,
    parameter logic [BUS_WIDTH-1:0] IDLE_FILL = '0
) (
    input logic        clk_f,
    input logic        reset,
    mux_l1_tx_if.slave bus
);
    typedef enum logic {
        IDLE,
        SEND_HI
    } state_t;

    logic [1:0][BUS_WIDTH-1:0] lo_data, hi_data;
    logic [1:0]                lo_valid, hi_valid;

    state_t                    state_q [2];
    state_t                    state_d [2];
    logic [1:0][BUS_WIDTH-1:0] sal_q, sal_d, hold_q, hold_d;
    logic [1:0]                vsal_q, vsal_d, vhold_q, vhold_d, ovf_q, ovf_d;

    assign lo_data  = {bus.Entrada2, bus.Entrada0};
    assign hi_data  = {bus.Entrada3, bus.Entrada1};
    assign lo_valid = {bus.validEntrada2, bus.validEntrada0};
    assign hi_valid = {bus.validEntrada3, bus.validEntrada1};

    always_ff @(posedge clk_f) begin
        for (int unsigned k = 0; k < 2; k++) begin
            if (reset) begin
                state_q[k] <= IDLE;
                hold_q[k]  <= IDLE_FILL;
                vhold_q[k] <= 1'b0;
                sal_q[k]   <= IDLE_FILL;
                vsal_q[k]  <= 1'b0;
                ovf_q[k]   <= 1'b0;
            end else begin
                state_q[k] <= state_d[k];
                hold_q[k]  <= hold_d[k];
                vhold_q[k] <= vhold_d[k];
                sal_q[k]   <= sal_d[k];
                vsal_q[k]  <= vsal_d[k];
                ovf_q[k]   <= ovf_d[k];
            end
        end
    end

    // Empty slots always drive IDLE_FILL so stale lane data never leaks out.
    always_comb begin
        for (int unsigned k = 0; k < 2; k++) begin
            state_d[k] = state_q[k];
            hold_d[k]  = hold_q[k];
            vhold_d[k] = vhold_q[k];
            sal_d[k]   = IDLE_FILL;
            vsal_d[k]  = 1'b0;
            ovf_d[k]   = ovf_q[k];
            case (state_q[k])
                IDLE: begin
                    if (lo_valid[k] | hi_valid[k]) begin
                        sal_d[k]   = lo_valid[k] ? lo_data[k] : IDLE_FILL;
                        vsal_d[k]  = lo_valid[k];
                        hold_d[k]  = hi_data[k];
                        vhold_d[k] = hi_valid[k];
                        state_d[k] = SEND_HI;
                    end
                end
                SEND_HI: begin
                    sal_d[k]   = vhold_q[k] ? hold_q[k] : IDLE_FILL;
                    vsal_d[k]  = vhold_q[k];
                    state_d[k] = IDLE;
                    if (lo_valid[k] | hi_valid[k]) begin
                        ovf_d[k] = 1'b1;
                    end
                end
                default: state_d[k] = IDLE;
            endcase
        end
    end

    assign bus.ready0       = (state_q[0] == IDLE);
    assign bus.ready1       = (state_q[1] == IDLE);
    assign bus.Salida0      = sal_q[0];
    assign bus.Salida1      = sal_q[1];
    assign bus.validsalida0 = vsal_q[0];
    assign bus.validsalida1 = vsal_q[1];
    assign bus.overflow0    = ovf_q[0];
    assign bus.overflow1    = ovf_q[1];
endmodule

// File: tb/tb_mux_l1_tx.sv
// Self-checking bench for mux_l1_tx: per-channel scoreboard queues of
// expected {valid, data} per output cycle, plus ready/overflow checks.
module tb_mux_l1_tx;
    typedef struct packed {
        logic       v;
        logic [7:0] d;
    } exp_t;

    logic clk_f = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    exp_t q0[$];
    exp_t q1[$];

    mux_l1_tx_if #(.BUS_WIDTH(8)) bus ();

    mux_l1_tx #(.BUS_WIDTH(8), .IDLE_FILL(8'h00)) dut (
        .clk_f (clk_f),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk_f = ~clk_f;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk_f);
        #1;
    endtask

    task automatic set_ch0(input logic [7:0] lo, input logic [7:0] hi, input logic vlo, input logic vhi);
        bus.Entrada0 = lo; bus.Entrada1 = hi; bus.validEntrada0 = vlo; bus.validEntrada1 = vhi;
    endtask

    task automatic set_ch1(input logic [7:0] lo, input logic [7:0] hi, input logic vlo, input logic vhi);
        bus.Entrada2 = lo; bus.Entrada3 = hi; bus.validEntrada2 = vlo; bus.validEntrada3 = vhi;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        set_ch0(8'h00, 8'h00, 1'b0, 1'b0);
        set_ch1(8'h00, 8'h00, 1'b0, 1'b0);
        repeat (3) tick();
        reset = 1'b0;
        checks++;
        if ({bus.validsalida0, bus.Salida0, bus.validsalida1, bus.Salida1} !== 18'h0) begin
            errors++;
            $display("FAIL reset_out: got v0=%b s0=%h v1=%b s1=%h, required all 0", bus.validsalida0, bus.Salida0, bus.validsalida1, bus.Salida1);
        end
        checks++;
        if ({bus.ready0, bus.ready1} !== 2'b11) begin
            errors++;
            $display("FAIL reset_ready: got %b%b, required 11", bus.ready0, bus.ready1);
        end
        checks++;
        if ({bus.overflow0, bus.overflow1} !== 2'b00) begin
            errors++;
            $display("FAIL reset_ovf: got %b%b, required 00", bus.overflow0, bus.overflow1);
        end
    endtask

    task automatic test_single_pair();
        exp_t e;
        q0.push_back('{1'b1, 8'hA1});
        q0.push_back('{1'b1, 8'hB2});
        q0.push_back('{1'b0, 8'h00});
        set_ch0(8'hA1, 8'hB2, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            set_ch0(8'h00, 8'h00, 1'b0, 1'b0);
            e = q0.pop_front();
            checks++;
            if ({bus.validsalida0, bus.Salida0} !== {e.v, e.d}) begin
                errors++;
                $display("FAIL pair_slot%0d: got v=%b d=%h, required v=%b d=%h", i, bus.validsalida0, bus.Salida0, e.v, e.d);
            end
            if (i == 0) begin
                checks++;
                if (bus.ready0 !== 1'b0) begin
                    errors++;
                    $display("FAIL pair_ready_send_hi: got %b, required 0", bus.ready0);
                end
            end
        end
        checks++;
        if (bus.ready0 !== 1'b1) begin
            errors++;
            $display("FAIL pair_ready_idle: got %b, required 1", bus.ready0);
        end
    endtask

    task automatic test_back_to_back();
        exp_t       e;
        logic [7:0] base;
        for (int p = 1; p <= 3; p++) begin
            base = 8'(p * 16);
            q1.push_back('{1'b1, base});
            q1.push_back('{1'b1, base + 8'h01});
        end
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0) begin
                base = 8'((i / 2 + 1) * 16);
                set_ch1(base, base + 8'h01, 1'b1, 1'b1);
            end else begin
                set_ch1(8'h00, 8'h00, 1'b0, 1'b0);
            end
            tick();
            e = q1.pop_front();
            checks++;
            if ({bus.validsalida1, bus.Salida1} !== {e.v, e.d}) begin
                errors++;
                $display("FAIL b2b_slot%0d: got v=%b d=%h, required v=%b d=%h", i, bus.validsalida1, bus.Salida1, e.v, e.d);
            end
        end
        set_ch1(8'h00, 8'h00, 1'b0, 1'b0);
        checks++;
        if (bus.overflow1 !== 1'b0) begin
            errors++;
            $display("FAIL b2b_ovf: got %b, required 0", bus.overflow1);
        end
        tick();
    endtask

    task automatic test_partial();
        exp_t e;
        q0.push_back('{1'b0, 8'h00});
        q0.push_back('{1'b1, 8'h5C});
        set_ch0(8'h77, 8'h5C, 1'b0, 1'b1);
        for (int i = 0; i < 2; i++) begin
            tick();
            set_ch0(8'h99, 8'h00, 1'b0, 1'b0);
            e = q0.pop_front();
            checks++;
            if ({bus.validsalida0, bus.Salida0} !== {e.v, e.d}) begin
                errors++;
                $display("FAIL partial_slot%0d: got v=%b d=%h, required v=%b d=%h", i, bus.validsalida0, bus.Salida0, e.v, e.d);
            end
        end
        tick();
    endtask

    task automatic test_overflow();
        exp_t e;
        q0.push_back('{1'b1, 8'hC3});
        q0.push_back('{1'b1, 8'hD4});
        q0.push_back('{1'b0, 8'h00});
        q0.push_back('{1'b0, 8'h00});
        q0.push_back('{1'b0, 8'h00});
        set_ch0(8'hC3, 8'hD4, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            tick();
            if (i == 0) set_ch0(8'hE5, 8'hF6, 1'b1, 1'b1);
            else        set_ch0(8'h00, 8'h00, 1'b0, 1'b0);
            e = q0.pop_front();
            checks++;
            if ({bus.validsalida0, bus.Salida0} !== {e.v, e.d}) begin
                errors++;
                $display("FAIL ovf_slot%0d: got v=%b d=%h, required v=%b d=%h", i, bus.validsalida0, bus.Salida0, e.v, e.d);
            end
            checks++;
            if (bus.overflow0 !== (i >= 1)) begin
                errors++;
                $display("FAIL ovf_flag%0d: got %b, required %b", i, bus.overflow0, (i >= 1));
            end
            checks++;
            if ({bus.validsalida1, bus.overflow1, bus.ready1} !== 3'b001) begin
                errors++;
                $display("FAIL ovf_ch1_isolation%0d: got v1=%b ovf1=%b rdy1=%b, required 0 0 1", i, bus.validsalida1, bus.overflow1, bus.ready1);
            end
        end
    endtask

    task automatic test_reset_send_hi();
        set_ch0(8'h11, 8'hEE, 1'b1, 1'b1);
        tick();
        checks++;
        if ({bus.validsalida0, bus.Salida0, bus.ready0} !== {1'b1, 8'h11, 1'b0}) begin
            errors++;
            $display("FAIL rst_hi_accept: got v=%b d=%h rdy=%b, required 1 11 0", bus.validsalida0, bus.Salida0, bus.ready0);
        end
        // Offer stays asserted through the reset edge: reset must win.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        set_ch0(8'h00, 8'h00, 1'b0, 1'b0);
        checks++;
        if ({bus.validsalida0, bus.Salida0, bus.ready0, bus.overflow0} !== {1'b0, 8'h00, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL rst_hi_after: got v=%b d=%h rdy=%b ovf=%b, required 0 00 1 0", bus.validsalida0, bus.Salida0, bus.ready0, bus.overflow0);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if ({bus.validsalida0, bus.Salida0} !== {1'b0, 8'h00}) begin
                errors++;
                $display("FAIL rst_hi_discard%0d: got v=%b d=%h, required 0 00", i, bus.validsalida0, bus.Salida0);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_pair();
        test_back_to_back();
        test_partial();
        test_overflow();
        test_reset_send_hi();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
